// File: rtl/rat_intr_ctrl.sv
// RAT interrupt controller: synchronise/debounce raw request lines, latch rising edges as
// pending, mask, and sequence one INTR pulse per service episode. MCU access via IN/OUT ports.
module rat_db_lane #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          s1, s2, db, db_q;
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronised input disagrees with the accepted state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = db & ~db_q;
endmodule

module rat_intr_ctrl #(
    parameter int         N_SRC     = 8,
    parameter int         DB_CYCLES = 1000,
    parameter int         INTR_CYC  = 2,
    parameter logic [7:0] STAT_ADDR = 8'h30,
    parameter logic [7:0] MASK_ADDR = 8'h31,
    parameter logic [7:0] ID_ADDR   = 8'h32,
    parameter logic [7:0] CLR_ADDR  = 8'h33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_raw,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             io_strb,
    output logic [7:0]       in_data,
    output logic             intr
);
    localparam int PW = $clog2(INTR_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT} state_t;

    state_t           state;
    logic [PW-1:0]    pcnt;
    logic [N_SRC-1:0] rise, pending, mask, clr, en;
    logic             req;
    logic [2:0]       id;
    logic [7:0]       stat_w, mask_w;

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        rat_db_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
            .clk (clk),
            .rst (rst),
            .raw (irq_raw[i]),
            .rise(rise[i])
        );
    end

    assign clr = (io_strb && port_id == CLR_ADDR) ? out_port[N_SRC-1:0] : '0;
    assign en  = pending & mask;
    assign req = |en;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            // OR-ing rise after the clear makes a same-cycle set win.
            pending <= (pending & ~clr) | rise;
            if (io_strb && port_id == MASK_ADDR)
                mask <= out_port[N_SRC-1:0];
        end
    end

    // WAIT only rearms once every enabled pending bit is gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            intr  <= 1'b0;
            pcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    state <= S_ASSERT;
                    intr  <= 1'b1;
                    pcnt  <= PW'(INTR_CYC - 1);
                end
                S_ASSERT: if (pcnt == '0) begin
                    state <= S_WAIT;
                    intr  <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1'b1;
                end
                S_WAIT: if (!req) state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (en[i]) id = 3'(i);
    end

    always_comb begin
        stat_w = '0;
        mask_w = '0;
        stat_w[N_SRC-1:0] = pending;
        mask_w[N_SRC-1:0] = mask;
        case (port_id)
            STAT_ADDR: in_data = stat_w;
            MASK_ADDR: in_data = mask_w;
            ID_ADDR:   in_data = {req, 4'b0000, id};
            default:   in_data = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed bench for rat_intr_ctrl: debounce, pending/mask/ID reads, pulse shape and rearm rules.
module tb_rat_intr_ctrl;
    localparam int DB = 40;
    localparam logic [7:0] STAT = 8'h30, MASK = 8'h31, IDA = 8'h32, CLR = 8'h33;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_raw, port_id, out_port, in_data;
    logic       io_strb, intr;

    int n_chk = 0, n_pass = 0;
    int hi_cnt = 0, rise_cnt = 0;
    logic intr_d = 1'b0;
    int r0;
    logic [7:0] v;

    rat_intr_ctrl #(.N_SRC(8), .DB_CYCLES(DB), .INTR_CYC(2)) dut (
        .clk(clk), .rst(rst), .irq_raw(irq_raw), .port_id(port_id),
        .out_port(out_port), .io_strb(io_strb), .in_data(in_data), .intr(intr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (intr) hi_cnt <= hi_cnt + 1;
        if (intr && !intr_d) rise_cnt <= rise_cnt + 1;
        intr_d <= intr;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        port_id = a;
        #1;
        d = in_data;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        port_id  = a;
        out_port = d;
        io_strb  = 1'b1;
        tick();
        io_strb  = 1'b0;
    endtask

    // Bounded wait for STAT to reach exp; a timeout shows up as a failed compare.
    task automatic wait_stat(input string tag, input logic [7:0] exp);
        port_id = STAT;
        #1;
        for (int i = 0; i < DB + 20; i++) begin
            if (in_data == exp) break;
            tick();
        end
        chk(tag, in_data, exp);
    endtask

    // Called in the cycle pending was first set (FSM idle): INTR 0, 1, 1, 0.
    task automatic pulse_chk(input string tag);
        chk({tag, "_t0"}, {7'b0, intr}, 8'h00);
        tick();
        chk({tag, "_t1"}, {7'b0, intr}, 8'h01);
        tick();
        chk({tag, "_t2"}, {7'b0, intr}, 8'h01);
        tick();
        chk({tag, "_t3"}, {7'b0, intr}, 8'h00);
    endtask

    initial begin
        rst = 1'b1; irq_raw = '0; port_id = '0; out_port = '0; io_strb = 1'b0;
        repeat (3) tick();

        // 1: reset state, single source service
        chk("rst_intr", {7'b0, intr}, 8'h00);
        rd(STAT, v); chk("rst_stat", v, 8'h00);
        rd(MASK, v); chk("rst_mask", v, 8'h00);
        rd(IDA, v);  chk("rst_id", v, 8'h00);
        rst = 1'b0;
        io_wr(MASK, 8'h01);
        rd(MASK, v); chk("mask_wr", v, 8'h01);
        port_id = MASK; out_port = 8'hFF; tick();
        rd(MASK, v); chk("mask_nostrb", v, 8'h01);
        rd(8'h34, v); chk("unmapped", v, 8'h00);
        r0 = hi_cnt;
        irq_raw[0] = 1'b1;
        wait_stat("t1_stat", 8'h01);
        pulse_chk("t1_pulse");
        repeat (5) tick();
        chk("t1_hicnt", 8'(hi_cnt - r0), 8'h02);
        rd(IDA, v); chk("t1_id", v, 8'h80);
        io_wr(CLR, 8'h01);
        rd(STAT, v); chk("t1_clr", v, 8'h00);
        irq_raw[0] = 1'b0;
        repeat (DB + 10) tick();
        rd(STAT, v); chk("t1_fall", v, 8'h00);

        // 2: bounce shorter than the debounce window is rejected
        r0 = rise_cnt;
        for (int i = 0; i < 20; i++) begin
            irq_raw[0] = ~irq_raw[0];
            repeat (10) tick();
        end
        irq_raw[0] = 1'b0;
        repeat (DB + 10) tick();
        rd(STAT, v); chk("t2_stat", v, 8'h00);
        chk("t2_nointr", 8'(rise_cnt - r0), 8'h00);

        // 3: masked source latches; unmasking triggers service
        io_wr(MASK, 8'h00);
        r0 = rise_cnt;
        irq_raw[2] = 1'b1;
        wait_stat("t3_stat", 8'h04);
        repeat (5) tick();
        chk("t3_masked", 8'(rise_cnt - r0), 8'h00);
        rd(IDA, v); chk("t3_id_masked", v, 8'h00);
        io_wr(MASK, 8'h04);
        pulse_chk("t3_pulse");
        rd(IDA, v); chk("t3_id", v, 8'h82);
        io_wr(CLR, 8'h04);
        rd(STAT, v); chk("t3_clr", v, 8'h00);
        irq_raw[2] = 1'b0;
        repeat (DB + 10) tick();

        // 4: two sources together, single pulse, priority ID, rearm
        io_wr(MASK, 8'hFF);
        r0 = rise_cnt;
        irq_raw[5] = 1'b1; irq_raw[1] = 1'b1;
        wait_stat("t4_stat", 8'h22);
        pulse_chk("t4_pulse");
        rd(IDA, v); chk("t4_id1", v, 8'h81);
        io_wr(CLR, 8'h02);
        rd(IDA, v); chk("t4_id5", v, 8'h85);
        repeat (10) tick();
        chk("t4_one_pulse", 8'(rise_cnt - r0), 8'h01);
        io_wr(CLR, 8'h20);
        rd(IDA, v); chk("t4_id_none", v, 8'h00);
        irq_raw[5] = 1'b0; irq_raw[1] = 1'b0;
        repeat (DB + 10) tick();
        irq_raw[3] = 1'b1;
        wait_stat("t4_stat3", 8'h08);
        pulse_chk("t4_pulse3");
        rd(IDA, v); chk("t4_id3", v, 8'h83);
        io_wr(CLR, 8'h08);
        irq_raw[3] = 1'b0;
        repeat (DB + 10) tick();

        // 5: clear coincident with a new set of the same bit; set wins
        irq_raw[0] = 1'b1;
        repeat (DB + 2) tick();
        io_wr(CLR, 8'h01);
        chk("t5_intr_idle", {7'b0, intr}, 8'h00);
        rd(STAT, v); chk("t5_setwins", v, 8'h01);
        tick();
        chk("t5_intr", {7'b0, intr}, 8'h01);
        io_wr(CLR, 8'h01);
        irq_raw[0] = 1'b0;
        repeat (DB + 10) tick();
        rd(STAT, v); chk("t5_clr", v, 8'h00);

        // 6: reset during ASSERT
        irq_raw[4] = 1'b1;
        wait_stat("t6_stat", 8'h10);
        tick();
        chk("t6_assert", {7'b0, intr}, 8'h01);
        rst = 1'b1;
        tick();
        chk("t6_rst_intr", {7'b0, intr}, 8'h00);
        rd(STAT, v); chk("t6_rst_stat", v, 8'h00);
        rd(MASK, v); chk("t6_rst_mask", v, 8'h00);
        rst = 1'b0;
        r0 = rise_cnt;
        repeat (DB + 20) tick();
        chk("t6_no_pulse", 8'(rise_cnt - r0), 8'h00);
        rd(STAT, v); chk("t6_relatch", v, 8'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
